// File: rtl/counter_pkg.sv
// Shared constants for the loadable up-counter: default width and the value
// the count register returns to on reset.
package counter_pkg;

  localparam int COUNTER_WIDTH = 8;

  // Reset value for a single bit; replicated to the instance width where used.
  localparam logic COUNTER_RST_BIT = 1'b0;

endpackage

// File: rtl/counter_next.sv
// Combinational next-state selector for the counter: reset, load, count and
// hold in strict priority order, with a modulo-2^WIDTH increment.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic [WIDTH-1:0] cnt,
  input  logic             RST,
  input  logic             LOAD,
  input  logic             COUNT,
  input  logic [WIDTH-1:0] COUNT_IN,
  output logic [WIDTH-1:0] cnt_next
);

  logic [WIDTH-1:0] cnt_inc;

  // Carry out of the MSB is dropped, so all-ones wraps straight to zero.
  assign cnt_inc = cnt + WIDTH'(1);

  always_comb begin
    cnt_next = cnt;
    if (!RST) begin
      cnt_next = {WIDTH{COUNTER_RST_BIT}};
    end else if (LOAD) begin
      cnt_next = COUNT_IN;
    end else if (COUNT) begin
      cnt_next = cnt_inc;
    end
  end

endmodule

// File: rtl/counter.sv
// Loadable up-counter with count enable and synchronous active-low reset;
// the output is driven straight from the count register.
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             COUNT,
  input  logic [WIDTH-1:0] COUNT_IN,
  input  logic             LOAD,
  output logic [WIDTH-1:0] COUNT_OUT
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .cnt     (cnt_q),
    .RST     (RST),
    .LOAD    (LOAD),
    .COUNT   (COUNT),
    .COUNT_IN(COUNT_IN),
    .cnt_next(cnt_d)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q <= {WIDTH{COUNTER_RST_BIT}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign COUNT_OUT = cnt_q;

endmodule

// File: tb/tb_counter.sv
// Scoreboard bench for the loadable counter: directed sequences followed by
// randomized traffic, checked against an arithmetic reference model.
module tb_counter;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic         COUNT;
  logic [W-1:0] COUNT_IN;
  logic         LOAD;
  logic [W-1:0] COUNT_OUT;

  int tests;
  int fails;
  int model;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  counter #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .COUNT    (COUNT),
    .COUNT_IN (COUNT_IN),
    .LOAD     (LOAD),
    .COUNT_OUT(COUNT_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs on the falling edge and queue the value the
  // counter must show after the next rising edge.
  task automatic step(input logic rst, input logic ld, input logic cnt,
                      input logic [W-1:0] din, input string tag);
    @(negedge CLK);
    RST      = rst;
    LOAD     = ld;
    COUNT    = cnt;
    COUNT_IN = din;
    if (!rst)      model = 0;
    else if (ld)   model = int'(din);
    else if (cnt)  model = (model + 1) % (1 << W);
    exp_q.push_back(W'(model));
    tag_q.push_back(tag);
  endtask

  // Monitor: every rising edge presents a result; compare it 1ns later.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        automatic logic [W-1:0] e = exp_q.pop_front();
        automatic string        t = tag_q.pop_front();
        tests++;
        if (COUNT_OUT !== e) begin
          fails++;
          $display("FAIL %s: COUNT_OUT got %h expected %h at %0t", t, COUNT_OUT, e, $time);
        end
      end
    end
  end

  initial begin
    tests    = 0;
    fails    = 0;
    model    = 0;
    RST      = 1'b0;
    LOAD     = 1'b1;
    COUNT    = 1'b1;
    COUNT_IN = 8'h03;

    step(0, 1, 1, 8'h03, "reset");
    step(0, 1, 1, 8'h03, "reset");

    step(1, 1, 0, 8'h04, "load");
    step(1, 1, 0, 8'h05, "load");

    step(1, 1, 1, 8'h05, "prio");
    step(1, 0, 0, 8'hA7, "hold");
    step(1, 0, 0, 8'h3C, "hold");

    for (int i = 0; i < 4; i++) step(1, 0, 1, 8'h00, "count");
    step(1, 0, 0, 8'h77, "count_hold");

    step(1, 1, 0, 8'hFE, "wrap_load");
    for (int i = 0; i < 3; i++) step(1, 0, 1, 8'h00, "wrap");

    step(1, 1, 0, 8'h20, "rstmid_load");
    step(0, 0, 1, 8'h00, "rstmid");
    step(1, 0, 1, 8'h00, "rstmid_resume");

    // Held load with count high reloads every edge.
    step(1, 1, 1, 8'h80, "held_load");
    step(1, 1, 1, 8'h81, "held_load");

    // Long count run crossing the wrap point.
    step(1, 1, 0, 8'hF0, "run_load");
    for (int i = 0; i < 40; i++) step(1, 0, 1, 8'h00, "run");

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) != 0), ($urandom_range(7) == 0),
           ($urandom_range(3) != 0), W'($urandom), "rand");
    end

    repeat (4) @(posedge CLK);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: pending %0d expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
